// File: rtl/dvp_frame_transmitter.sv
// dvp_frame_transmitter: drives the sensor side of a DVP/SCI camera bus
// (PCLK, HREF, VSYNC, DATA[7:0]) with OV7670-style RGB565 timing. It stands in
// for a real sensor. Pixel content is a built-in pattern or an external stream.
// Ports:
//   clk, rst_n           system clock, async active-low reset; PCLK = clk/2
//   enable               start a frame at the next frame boundary
//   pattern_sel          0 bars, 1 counter, 2 external stream, 3 solid fill_color
//   fill_color           RGB565 solid colour for pattern 3
//   pix_data, pix_valid  external RGB565 pixel and its valid flag
//   pix_ready            one-clk request for the next external pixel
//   underflow_clr        clears the sticky underflow flag
//   cam_pclk/vsync/href/data  camera bus
//   frame_done           one-clk pulse at the end of the front porch
//   underflow            sticky: an external pixel was missing when requested
module dvp_frame_transmitter #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned CNT_W       = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] fill_color,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        underflow_clr,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        underflow
);

    localparam int unsigned LINE_T = 2 * H_ACTIVE + H_BLANK;

    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_T - 1);
    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(2 * H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VSYNC_LINES - 1);
    localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(V_BACK - 1);
    localparam logic [CNT_W-1:0] VF_LAST   = CNT_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0] VA_LINES  = CNT_W'(V_ACTIVE);

    // Column counter spans one line-time, line counter spans the longest vertical region.
    localparam bit CNT_OK = (((LINE_T - 1) >> CNT_W) == 0) && ((V_ACTIVE >> CNT_W) == 0) &&
                            (((VSYNC_LINES - 1) >> CNT_W) == 0) && (((V_BACK - 1) >> CNT_W) == 0) &&
                            (((V_FRONT - 1) >> CNT_W) == 0);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
    } state_e;

    state_e             st_q, st_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   line_q, line_d;
    logic [1:0]         pat_q, pat_d;
    logic [15:0]        fill_q, fill_d;
    logic [15:0]        pix_q, pix_d;
    logic               ph_q;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic [7:0]         data_q, data_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               uf_q, uf_d;

    logic               tick_c;
    logic               line_end_c;
    logic [CNT_W-1:0]   line_inc_c;
    logic [CNT_W-1:0]   col_c;
    logic [2:0]         bar_c;
    logic [15:0]        pix_in_c;
    logic [15:0]        px_c;

    assign tick_c     = ph_q;
    assign line_end_c = (cnt_q == LINE_LAST);
    assign line_inc_c = line_q + CNT_W'(1);

    // State, counters and output registers; the frame machinery moves only on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            pat_q   <= '0;
            fill_q  <= '0;
            pix_q   <= '0;
            ph_q    <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            ph_q    <= ~ph_q;
            ready_q <= ready_d;
            done_q  <= done_d;
            uf_q    <= uf_d;
            if (tick_c) begin
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                line_q  <= line_d;
                pat_q   <= pat_d;
                fill_q  <= fill_d;
                pix_q   <= pix_d;
                vsync_q <= vsync_d;
                href_q  <= href_d;
                data_q  <= data_d;
            end
        end
    end

    // Next state: what the machine becomes at the coming tick.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + CNT_W'(1);
        line_d = line_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        unique case (st_q)
            S_IDLE: begin
                cnt_d  = '0;
                line_d = '0;
                if (enable) begin
                    st_d   = S_VSYNC;
                    pat_d  = pattern_sel;
                    fill_d = fill_color;
                end
            end
            S_VSYNC: begin
                if (line_end_c) begin
                    cnt_d  = '0;
                    line_d = line_inc_c;
                    if (line_q == VS_LAST) begin
                        st_d   = S_VBACK;
                        line_d = '0;
                    end
                end
            end
            S_VBACK: begin
                if (line_end_c) begin
                    cnt_d  = '0;
                    line_d = line_inc_c;
                    if (line_q == VB_LAST) begin
                        st_d   = S_ACTIVE;
                        line_d = '0;
                    end
                end
            end
            S_ACTIVE: begin
                if (cnt_q == ACT_LAST) st_d = S_HBLANK;
            end
            S_HBLANK: begin
                if (line_end_c) begin
                    cnt_d = '0;
                    if (line_inc_c < VA_LINES) begin
                        st_d   = S_ACTIVE;
                        line_d = line_inc_c;
                    end else begin
                        st_d   = S_VFRONT;
                        line_d = '0;
                    end
                end
            end
            S_VFRONT: begin
                if (line_end_c) begin
                    cnt_d  = '0;
                    line_d = line_inc_c;
                    if (line_q == VF_LAST) begin
                        line_d = '0;
                        if (enable) begin
                            st_d   = S_VSYNC;
                            pat_d  = pattern_sel;
                            fill_d = fill_color;
                        end else begin
                            st_d = S_IDLE;
                        end
                    end
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Outputs for the coming tick, derived from the next state and counters.
    always_comb begin
        col_c    = cnt_d >> 1;
        bar_c    = 3'((32'(col_c) << 3) / H_ACTIVE);
        pix_in_c = pix_valid ? pix_data : 16'h0000;
        unique case (pat_q)
            2'd0: begin
                unique case (bar_c)
                    3'd0:    px_c = 16'hFFFF;
                    3'd1:    px_c = 16'hFFE0;
                    3'd2:    px_c = 16'h07FF;
                    3'd3:    px_c = 16'h07E0;
                    3'd4:    px_c = 16'hF81F;
                    3'd5:    px_c = 16'hF800;
                    3'd6:    px_c = 16'h001F;
                    default: px_c = 16'h0000;
                endcase
            end
            2'd1:    px_c = {8'(line_d), 8'(col_c)};
            2'd2:    px_c = cnt_d[0] ? pix_q : pix_in_c;
            default: px_c = fill_q;
        endcase
        vsync_d = (st_d == S_VSYNC);
        href_d  = (st_d == S_ACTIVE);
        data_d  = href_d ? (cnt_d[0] ? px_c[7:0] : px_c[15:8]) : 8'h00;
        // The request is raised in the clk ending at the tick that emits a high byte.
        ready_d = !tick_c && (pat_q == 2'd2) && (st_d == S_ACTIVE) && !cnt_d[0];
        pix_d   = ready_q ? pix_in_c : pix_q;
        done_d  = tick_c && (st_q == S_VFRONT) && line_end_c && (line_q == VF_LAST);
        // A fresh underflow wins over a simultaneous clear.
        uf_d    = (tick_c && ready_q && !pix_valid) || (uf_q && !underflow_clr);
    end

    assign cam_pclk   = ph_q;
    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign pix_ready  = ready_q;
    assign frame_done = done_q;
    assign underflow  = uf_q;

    always_ff @(posedge clk) begin
        if (rst_n) assert (CNT_OK) else $error("dvp_frame_transmitter: CNT_W too narrow for the timing parameters");
    end

endmodule
